rr_merge2: RTL and testbench
============================

RR_MERGE2 -- requirements
Module: rr_merge2

Interface
REQ-001 Parameter: WIDTH, 8, data width of every data port.
REQ-002 Parameter: CNT_W, 16, width of each grant counter.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: a_data  input  WIDTH  source A word.
REQ-006 Port: a_valid  input  1  A word present.
REQ-007 Port: a_ready  output  1  A word accepted this cycle when high with a_valid.
REQ-008 Port: b_data  input  WIDTH  source B word.
REQ-009 Port: b_valid  input  1  B word present.
REQ-010 Port: b_ready  output  1  B word accepted this cycle when high with b_valid.
REQ-011 Port: out_data  output  WIDTH  head word of the output buffer.
REQ-012 Port: out_sel  output  1  source of out_data: 0 = A, 1 = B.
REQ-013 Port: out_valid  output  1  output buffer non-empty.
REQ-014 Port: out_ready  input  1  consumer takes the head word when high with out_valid.
REQ-015 Port: a_cnt, b_cnt  output  CNT_W each  saturating count of accepted A and B words.

Function
REQ-016 Transfers: a push occurs on valid&ready at a clock edge; a pop occurs on out_valid&out_ready.
REQ-017 The output buffer holds exactly 2 entries of {sel, data}, with an occupancy count of 0..2, and is FIFO-ordered.
REQ-018 Arbitration is combinational on the current inputs; at most one source is granted per cycle.
REQ-019 Only one source valid: that source is granted.
REQ-020 Both sources valid: grant the source not in register last_grant (round-robin).
REQ-021 last_grant updates to the granted source on each push and holds otherwise.
REQ-022 a_ready = grant_A & (count < 2); b_ready = grant_B & (count < 2); ready never depends on out_ready.
REQ-023 Latency: a word pushed at edge N drives out_data/out_valid from edge N onward (visible the cycle after acceptance) when the buffer was empty.
REQ-024 Push and pop in the same cycle with count = 1: count stays 1 and the new word becomes head.
REQ-025 Count = 2: no push; pop decrements to 1.
REQ-026 Count = 0: out_valid = 0; out_ready is ignored; out_data/out_sel hold their last values.
REQ-027 Counters: a_cnt/b_cnt increment by 1 per accepted word and saturate at 2^CNT_W-1 (no wrap).
REQ-028 Input data is sampled only at push; a_data/b_data changes without a handshake have no effect.

Reset
REQ-029 rst_n low: count = 0, out_valid = 0, out_data = 0, out_sel = 0, a_cnt = b_cnt = 0, last_grant = B (so A wins the first tie).
REQ-030 Reset asserted mid-transfer discards all buffered words immediately, without waiting for a clock.
REQ-031 a_ready and b_ready are 0 while rst_n is low.

Structure
REQ-032 A shared package holds constants SEL_A = 1'b0 and SEL_B = 1'b1 and the default WIDTH.
REQ-033 One sub-module, merge_obuf, implements the 2-entry {sel, data} FIFO with push/pop/count.
REQ-034 The arbiter, last_grant register and counters reside in rr_merge2.

Verification
REQ-035 The bench shall cover: A only, a_data=8'h11, out_ready=1 -> a_ready=1; next cycle out_data=8'h11, out_sel=0, a_cnt=1.
REQ-036 The bench shall cover: both valid every cycle (A=8'hAA, B=8'hBB) after reset, out_ready=1 -> output sequence AA, BB, AA, BB with strict alternation.
REQ-037 The bench shall cover: out_ready=0, A valid 3 cycles -> 2 pushes, then a_ready=0 on the third cycle; count = 2 holds and nothing is lost.
REQ-038 The bench shall cover: count=1 with simultaneous push and pop -> count stays 1 and the order is preserved.
REQ-039 The bench shall cover: CNT_W=2 with 5 A pushes -> a_cnt=3 and held.
REQ-040 The bench shall cover: rst_n pulsed low with count=2 -> out_valid=0 immediately; after release, first tie granted to A.

Source files
------------

// File: rtl/rr_merge2_pkg.sv
// Shared constants for the two-source round-robin merge.
package rr_merge2_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = 16;

    // Source tag carried with every buffered word.
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/rr_merge2_if.sv
// Handshake bundle for rr_merge2: two input streams, one output stream, counters.
interface rr_merge2_if
    import rr_merge2_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
);

    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_sel;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] a_cnt;
    logic [CNT_W-1:0] b_cnt;

    // The merge block itself.
    modport slave (
        input  a_data, a_valid, b_data, b_valid, out_ready,
        output a_ready, b_ready, out_data, out_sel, out_valid, a_cnt, b_cnt
    );

    // Whoever drives the sources and consumes the output.
    modport master (
        output a_data, a_valid, b_data, b_valid, out_ready,
        input  a_ready, b_ready, out_data, out_sel, out_valid, a_cnt, b_cnt
    );

endinterface

// File: rtl/rr_merge2_merge_obuf.sv
// Two-entry FIFO of {sel, data}. The head register keeps its last value
// when the buffer drains, so out_data/out_sel hold while empty.
module merge_obuf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             push_sel,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_sel,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);

    logic             tail_sel;
    logic [WIDTH-1:0] tail_data;
    logic             push_ok;
    logic             pop_ok;

    // A pop on an empty buffer or a push into a full one is ignored.
    assign pop_ok  = pop  && (count != 2'd0);
    assign push_ok = push && (count != 2'd2);

    // Occupancy and entry registers; the head is always entry 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is only two words, so it is reset outright; that gives the
            // defined zero head value on out_data instead of X after reset.
            count     <= 2'd0;
            head_sel  <= 1'b0;
            head_data <= '0;
            tail_sel  <= 1'b0;
            tail_data <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values;
            // the shift tail->head below relies on that.
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase

            if (pop_ok) begin
                if (count == 2'd2) begin
                    head_sel  <= tail_sel;
                    head_data <= tail_data;
                end else if (push_ok) begin
                    head_sel  <= push_sel;
                    head_data <= push_data;
                end
            end else if (push_ok) begin
                if (count == 2'd0) begin
                    head_sel  <= push_sel;
                    head_data <= push_data;
                end else begin
                    tail_sel  <= push_sel;
                    tail_data <= push_data;
                end
            end
        end
    end

endmodule

// File: rtl/rr_merge2.sv
// Round-robin merge of two valid/ready streams into a 2-deep output buffer,
// with saturating per-source acceptance counters.
module rr_merge2
    import rr_merge2_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic      clk,
    input  logic      rst_n,
    rr_merge2_if.slave bus
);

    logic             last_grant;
    logic             grant_a;
    logic             grant_b;
    logic             a_push;
    logic             b_push;
    logic [1:0]       count;
    logic             push_sel;
    logic [WIDTH-1:0] push_data;

    // Arbitration on current inputs: a lone requester wins, a tie goes to
    // the source that did not win last.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves
        // it unassigned, which would infer a latch.
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        push_sel  = SEL_A;
        push_data = bus.a_data;
        if (bus.a_valid && bus.b_valid) begin
            grant_a = (last_grant == SEL_B);
            grant_b = (last_grant == SEL_A);
        end else begin
            grant_a = bus.a_valid;
            grant_b = bus.b_valid;
        end
        if (grant_b) begin
            push_sel  = SEL_B;
            push_data = bus.b_data;
        end
    end

    // Ready is gated by reset so nothing is offered while rst_n is low.
    assign bus.a_ready = rst_n && grant_a && (count != 2'd2);
    assign bus.b_ready = rst_n && grant_b && (count != 2'd2);
    assign a_push      = bus.a_ready && bus.a_valid;
    assign b_push      = bus.b_ready && bus.b_valid;
    assign bus.out_valid = (count != 2'd0);

    merge_obuf #(.WIDTH(WIDTH)) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (a_push || b_push),
        .push_sel  (push_sel),
        .push_data (push_data),
        .pop       (bus.out_ready),
        .head_sel  (bus.out_sel),
        .head_data (bus.out_data),
        .count     (count)
    );

    // Round-robin pointer and saturating acceptance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= SEL_B;
            bus.a_cnt  <= '0;
            bus.b_cnt  <= '0;
        end else begin
            if (a_push) begin
                last_grant <= SEL_A;
            end else if (b_push) begin
                last_grant <= SEL_B;
            end
            if (a_push && (bus.a_cnt != {CNT_W{1'b1}})) begin
                bus.a_cnt <= bus.a_cnt + CNT_W'(1);
            end
            if (b_push && (bus.b_cnt != {CNT_W{1'b1}})) begin
                bus.b_cnt <= bus.b_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rr_merge2.sv
// Self-checking bench for rr_merge2: a queue-based model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_rr_merge2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_merge2_if #(.WIDTH(8), .CNT_W(16)) bus ();
    rr_merge2_if #(.WIDTH(8), .CNT_W(2))  bus2 ();

    rr_merge2 #(.WIDTH(8), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    rr_merge2 #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    typedef struct packed {
        logic       sel;
        logic [7:0] data;
    } ent_t;

    // Behavioural model: FIFO of accepted words, the word last shown at the
    // head, round-robin winner and counters.
    ent_t        q[$];
    ent_t        held;
    logic        m_last;
    int unsigned m_acnt;
    int unsigned m_bcnt;
    logic        e_push_a, e_push_b, e_pop;
    logic [7:0]  e_adata, e_bdata;

    int checks   = 0;
    int failures = 0;
    logic [7:0] seq[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        held   = '0;
        m_last = 1'b1;
        m_acnt = 0;
        m_bcnt = 0;
    endtask

    // Drive inputs at the falling edge, then compare every output to the model.
    task automatic set_in(input logic av, input logic [7:0] ad, input logic bv,
                          input logic [7:0] bd, input logic ordy);
        logic ga, gb, ra, rb;
        ent_t exp_head;
        @(negedge clk);
        bus.a_valid   = av;
        bus.a_data    = ad;
        bus.b_valid   = bv;
        bus.b_data    = bd;
        bus.out_ready = ordy;
        #1;
        if (av && bv) begin
            ga = m_last;
            gb = !m_last;
        end else begin
            ga = av;
            gb = bv;
        end
        ra = rst_n && ga && (q.size() < 2);
        rb = rst_n && gb && (q.size() < 2);
        exp_head = (q.size() > 0) ? q[0] : held;
        check("a_ready",   32'(bus.a_ready),   32'(ra));
        check("b_ready",   32'(bus.b_ready),   32'(rb));
        check("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        check("out_data",  32'(bus.out_data),  32'(exp_head.data));
        check("out_sel",   32'(bus.out_sel),   32'(exp_head.sel));
        check("a_cnt",     32'(bus.a_cnt),     m_acnt);
        check("b_cnt",     32'(bus.b_cnt),     m_bcnt);
        e_push_a = ra && av;
        e_push_b = rb && bv;
        e_pop    = rst_n && ordy && (q.size() > 0);
        e_adata  = ad;
        e_bdata  = bd;
    endtask

    // Advance one clock and apply the transfers computed for this cycle.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (e_pop) held = q.pop_front();
            if (e_push_a) begin
                q.push_back('{sel: 1'b0, data: e_adata});
                m_last = 1'b0;
                if (m_acnt != 32'hFFFF) m_acnt++;
            end
            if (e_push_b) begin
                q.push_back('{sel: 1'b1, data: e_bdata});
                m_last = 1'b1;
                if (m_bcnt != 32'hFFFF) m_bcnt++;
            end
        end
        #1;
    endtask

    task automatic cycle(input logic av, input logic [7:0] ad, input logic bv,
                         input logic [7:0] bd, input logic ordy);
        set_in(av, ad, bv, bd, ordy);
        tick();
    endtask

    // Reset asserted between edges, held across one edge, released.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.a_valid = 0; bus.a_data = 0; bus.b_valid = 0; bus.b_data = 0; bus.out_ready = 0;
        bus2.a_valid = 0; bus2.a_data = 0; bus2.b_valid = 0; bus2.b_data = 0; bus2.out_ready = 0;
        model_reset();
        e_push_a = 0; e_push_b = 0; e_pop = 0; e_adata = 0; e_bdata = 0;

        // Reset values and ready held low during reset even with requests.
        #3;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data",  32'(bus.out_data),  0);
        check("rst_a_cnt",     32'(bus.a_cnt),     0);
        set_in(1'b1, 8'h55, 1'b1, 8'h66, 1'b1);
        check("rst_a_ready", 32'(bus.a_ready), 0);
        check("rst_b_ready", 32'(bus.b_ready), 0);
        tick();
        rst_n = 1'b1;

        // A only, 0x11: accepted, then visible with sel=A and a_cnt=1.
        set_in(1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
        check("a_only_ready", 32'(bus.a_ready), 1);
        tick();
        check("a_only_data", 32'(bus.out_data), 32'h11);
        check("a_only_sel",  32'(bus.out_sel),  0);
        check("a_only_cnt",  32'(bus.a_cnt),    1);
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Both valid every cycle after reset: strict alternation starting with A.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1);
            seq[i] = bus.out_data;
        end
        check("alt0", 32'(seq[0]), 32'hAA);
        check("alt1", 32'(seq[1]), 32'hBB);
        check("alt2", 32'(seq[2]), 32'hAA);
        check("alt3", 32'(seq[3]), 32'hBB);

        // Stalled consumer: two pushes, third refused, nothing lost.
        do_reset();
        set_in(1'b1, 8'h01, 1'b0, 8'h00, 1'b0);
        check("full_r1", 32'(bus.a_ready), 1);
        tick();
        set_in(1'b1, 8'h02, 1'b0, 8'h00, 1'b0);
        check("full_r2", 32'(bus.a_ready), 1);
        tick();
        set_in(1'b1, 8'h03, 1'b0, 8'h00, 1'b0);
        check("full_r3", 32'(bus.a_ready), 0);
        tick();
        check("full_head", 32'(bus.out_data), 32'h01);
        cycle(1'b1, 8'h03, 1'b0, 8'h00, 1'b1);
        check("full_pop_head", 32'(bus.out_data), 32'h02);
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Count 1 with push and pop together: new word becomes head, count stays 1.
        do_reset();
        cycle(1'b1, 8'h21, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 8'h22, 1'b1);
        check("pp_head",  32'(bus.out_data),  32'h22);
        check("pp_sel",   32'(bus.out_sel),   1);
        check("pp_valid", 32'(bus.out_valid), 1);
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        check("pp_empty", 32'(bus.out_valid), 0);
        check("pp_hold",  32'(bus.out_data),  32'h22);

        // Narrow counter instance saturates at 3 after 5 pushes and holds.
        do_reset();
        bus2.a_valid = 1'b1;
        bus2.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus2.a_data = 8'(i);
            cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        end
        check("sat_cnt", 32'(bus2.a_cnt), 3);
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        check("sat_hold", 32'(bus2.a_cnt), 3);
        bus2.a_valid = 1'b0;

        // Reset with a full buffer clears output at once; first tie goes to A.
        do_reset();
        cycle(1'b1, 8'h31, 1'b1, 8'h32, 1'b0);
        cycle(1'b1, 8'h31, 1'b1, 8'h32, 1'b0);
        check("pre_rst_valid", 32'(bus.out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", 32'(bus.out_valid), 0);
        check("async_data",  32'(bus.out_data),  0);
        model_reset();
        cycle(1'b1, 8'h41, 1'b1, 8'h42, 1'b1);
        rst_n = 1'b1;
        set_in(1'b1, 8'h41, 1'b1, 8'h42, 1'b1);
        check("tie_a", 32'(bus.a_ready), 1);
        check("tie_b", 32'(bus.b_ready), 0);
        tick();

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                  8'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
